magnitude_arbiter: RTL

- Round-robin scheduler that shares one gradient-magnitude unit among NUM_REQ Sobel lanes.
- Accepts (gx, gy) operand pairs over valid/ready, latches the granted pair onto the unit's a/b inputs and pulses its start.
- Detects the rising edge of the unit's completion flag and returns the 8-bit magnitude, tagged with the requester ID.
- Sits between the Sobel gradient stage and the threshold/output stage.

---
 rtl/edge_pkg.sv | 23 ++
 rtl/magnitude_arbiter_rr_grant.sv | 46 ++++
 rtl/magnitude_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_pkg
// Brief    : Shared widths, saturation constant and arbiter state encoding
//            for the edge-detection datapath.
// Revision : 1.0 - initial release
// ============================================================================
package edge_pkg;

    localparam int OP_W  = 11;
    localparam int MAG_W = 8;
    localparam logic [MAG_W-1:0] MAG_SAT = 8'hFF;

    // Arbiter states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/magnitude_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant
// Brief    : Combinational round-robin picker. Scans from rr_ptr+1 upward
//            with wrap-around and returns the first requesting lane.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    import edge_pkg::*;

    int              w_idx;
    logic [ID_W-1:0] w_sel;

    // Lane just served (rr_ptr) is visited last, giving it lowest priority
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        w_idx     = 0;
        w_sel     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = int'(rr_ptr) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_sel = w_idx[ID_W-1:0];
            if (!any_req && req[w_sel]) begin
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
                any_req      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/magnitude_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : magnitude_arbiter
// Brief    : Round-robin scheduler sharing one gradient-magnitude unit among
//            NUM_REQ Sobel lanes. Grants one (gx, gy) pair, pulses the unit's
//            start, waits for the rising edge of its completion flag and
//            returns the magnitude tagged with the owning lane ID.
//            Optional build macro MAG_ARB_TIMEOUT_EN adds a WAIT watchdog
//            that returns a saturated result and a sticky timeout_err.
// Revision : 1.0 - initial release
// ============================================================================
module magnitude_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int OP_W    = edge_pkg::OP_W,
    parameter  int MAG_W   = edge_pkg::MAG_W,
    parameter  int TIMEOUT = 64,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_gx,
    input  logic [NUM_REQ*OP_W-1:0] req_gy,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [MAG_W-1:0]        resp_mag,
    output logic [ID_W-1:0]         resp_id,
    output logic [OP_W-1:0]         mag_a,
    output logic [OP_W-1:0]         mag_b,
    output logic                    mag_start,
    input  logic [MAG_W-1:0]        mag_out,
    input  logic                    mag_out_valid,
`ifdef MAG_ARB_TIMEOUT_EN
    output logic                    busy,
    output logic                    timeout_err
`else
    output logic                    busy
`endif
);

    import edge_pkg::*;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("magnitude_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic                r_ovalid_d;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_any_req;
    logic [OP_W-1:0]     w_sel_gx;
    logic [OP_W-1:0]     w_sel_gy;
    logic                w_done;
    logic                w_timeout;

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_grant (
        .req       (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_req   (w_any_req)
    );

    assign w_sel_gx = req_gx[w_grant_idx*OP_W +: OP_W];
    assign w_sel_gy = req_gy[w_grant_idx*OP_W +: OP_W];

    // Completion is a rising edge only; a level held over from the last job
    // is already captured in r_ovalid_d during ISSUE and so is ignored.
    assign w_done = (r_state == WAIT) && mag_out_valid && !r_ovalid_d;

    assign busy = (r_state != IDLE);

`ifdef MAG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // Count WAIT cycles per job; flag a sticky error when the unit never answers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT && !w_done) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (!w_done && w_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Arbiter FSM: grant, issue one start pulse, wait for completion, hand off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= ID_W'(NUM_REQ - 1);
            r_ovalid_d <= 1'b0;
            req_ready  <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            mag_start  <= 1'b0;
            resp_valid <= 1'b0;
            resp_mag   <= '0;
            resp_id    <= '0;
        end else begin
            req_ready <= '0;
            mag_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        req_ready  <= w_grant;
                        mag_a      <= w_sel_gx;
                        mag_b      <= w_sel_gy;
                        resp_id    <= w_grant_idx;
                        r_rr_ptr   <= w_grant_idx;
                        mag_start  <= 1'b1;
                        r_ovalid_d <= 1'b0;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_ovalid_d <= mag_out_valid;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    r_ovalid_d <= mag_out_valid;
                    if (w_done) begin
                        resp_mag   <= mag_out;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end else if (w_timeout) begin
                        resp_mag   <= {MAG_W{1'b1}};
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
